// File: rtl/operand_fetch.sv
// Issue stage ahead of the 8-bit ALU: register file, busy scoreboard with writeback bypass,
// and a one-entry registered output slot that holds under downstream stall.
module operand_fetch (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [8:0] instr_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic       stall_i,
  input  logic       wb_en_i,
  input  logic [2:0] wb_addr_i,
  input  logic [7:0] wb_data_i,
  output logic [2:0] opcode_o,
  output logic [7:0] rs_data_o,
  output logic [7:0] rt_data_o,
  output logic [2:0] dest_o,
  output logic       dest_wr_o,
  output logic       valid_o
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [2:0] op_dec;
  logic [2:0] rs_idx;
  logic [2:0] rt_idx;
  logic       rt_used;
  logic       dest_wr;
  logic       wb_hit_rs;
  logic       wb_hit_rt;
  logic [7:0] rs_val;
  logic [7:0] rt_val;
  logic       hazard;
  logic       held;
  logic       issue;

  logic [7:0] rf_reg [8];
  logic [7:0] busy_reg;
  logic [7:0] busy_next;
  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic [2:0] opcode_reg;
  logic [7:0] rs_data_reg;
  logic [7:0] rt_data_reg;
  logic [2:0] dest_reg;
  logic       dest_wr_reg;

  assign op_dec = instr_i[8:6];
  assign rs_idx = instr_i[5:3];
  assign rt_idx = instr_i[2:0];

  // srl and abs are unary; slt and seq only produce a flag
  assign rt_used = !((op_dec == 3'b011) || (op_dec == 3'b110));
  assign dest_wr = !((op_dec == 3'b101) || (op_dec == 3'b111));

  assign wb_hit_rs = wb_en_i && (wb_addr_i == rs_idx);
  assign wb_hit_rt = wb_en_i && (wb_addr_i == rt_idx);
  assign rs_val    = wb_hit_rs ? wb_data_i : rf_reg[rs_idx];
  assign rt_val    = wb_hit_rt ? wb_data_i : rf_reg[rt_idx];

  assign hazard = (busy_reg[rs_idx] && !wb_hit_rs) ||
                  (rt_used && busy_reg[rt_idx] && !wb_hit_rt);
  assign held   = (state_reg == ST_FULL) && stall_i;

  assign instr_ready_o = !rst_i && !hazard && !held;
  assign issue         = instr_valid_i && instr_ready_o;

  // A new producer claiming a register outranks a writeback retiring the same register
  for (genvar gi = 0; gi < 8; gi++) begin : g_busy
    assign busy_next[gi] = (issue && dest_wr && (rs_idx == 3'(gi))) ||
                           (busy_reg[gi] && !(wb_en_i && (wb_addr_i == 3'(gi))));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (issue) state_next = ST_FULL;
      ST_FULL:  if (!issue && !stall_i) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) rf_reg[i] <= 8'h00;
      busy_reg    <= 8'h00;
      state_reg   <= ST_EMPTY;
      opcode_reg  <= 3'd0;
      rs_data_reg <= 8'h00;
      rt_data_reg <= 8'h00;
      dest_reg    <= 3'd0;
      dest_wr_reg <= 1'b0;
    end else begin
      if (wb_en_i) rf_reg[wb_addr_i] <= wb_data_i;
      busy_reg  <= busy_next;
      state_reg <= state_next;
      if (issue) begin
        opcode_reg  <= op_dec;
        rs_data_reg <= rs_val;
        rt_data_reg <= rt_val;
        dest_reg    <= rs_idx;
        dest_wr_reg <= dest_wr;
      end
    end
  end

  assign opcode_o  = opcode_reg;
  assign rs_data_o = rs_data_reg;
  assign rt_data_o = rt_data_reg;
  assign dest_o    = dest_reg;
  assign dest_wr_o = dest_wr_reg;
  assign valid_o   = (state_reg == ST_FULL);

endmodule

// File: tb/tb_operand_fetch.sv
// Checks operand_fetch against a register/scoreboard model each cycle: directed scenarios
// with literal expectations, then randomized traffic.
module tb_operand_fetch;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [8:0] instr_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic       stall_i;
  logic       wb_en_i;
  logic [2:0] wb_addr_i;
  logic [7:0] wb_data_i;
  logic [2:0] opcode_o;
  logic [7:0] rs_data_o;
  logic [7:0] rt_data_o;
  logic [2:0] dest_o;
  logic       dest_wr_o;
  logic       valid_o;

  operand_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .stall_i(stall_i), .wb_en_i(wb_en_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .opcode_o(opcode_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .dest_o(dest_o),
    .dest_wr_o(dest_wr_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [7:0] m_rf [8];
  bit         m_busy [8];
  bit         m_valid;
  logic [2:0] m_op, m_dest;
  logic [7:0] m_rs, m_rt;
  bit         m_dw;
  bit         last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check ready, clock, advance the model, check outputs.
  task automatic step(input bit rst, input bit iv, input logic [8:0] ins, input bit st,
                      input bit we, input logic [2:0] wa, input logic [7:0] wd);
    logic [2:0] op, rs, rt;
    bit uses_rt, writes, rs_wait, rt_wait, exp_ready, iss;
    @(negedge clk_i);
    rst_i = rst; instr_valid_i = iv; instr_i = ins; stall_i = st;
    wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
    op = ins[8:6]; rs = ins[5:3]; rt = ins[2:0];
    uses_rt = !(op inside {3'b011, 3'b110});
    writes  = !(op inside {3'b101, 3'b111});
    rs_wait = m_busy[rs] && !(we && wa == rs);
    rt_wait = uses_rt && m_busy[rt] && !(we && wa == rt);
    exp_ready = !rst && !rs_wait && !rt_wait && !(m_valid && st);
    #1;
    last_ready = instr_ready_o;
    chk("instr_ready", instr_ready_o, exp_ready);
    iss = iv && exp_ready;
    @(posedge clk_i);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_rf[i] = 8'h00; m_busy[i] = 0; end
      m_valid = 0; m_op = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_dw = 0;
    end else begin
      // applying the write first makes the register file itself show the bypassed value
      if (we) begin m_rf[wa] = wd; m_busy[wa] = 0; end
      if (iss) begin
        m_op = op; m_rs = m_rf[rs]; m_rt = m_rf[rt]; m_dest = rs; m_dw = writes;
        m_valid = 1;
        if (writes) m_busy[rs] = 1;
        $display("issue op=%0d rs=r%0d(0x%02h) rt=r%0d(0x%02h) dw=%0d t=%0t",
                 op, rs, m_rs, rt, m_rt, writes, $time);
      end else if (!(m_valid && st)) begin
        m_valid = 0;
      end
    end
    #1;
    chk("valid_o", valid_o, m_valid);
    chk("opcode_o", opcode_o, m_op);
    chk("rs_data_o", rs_data_o, m_rs);
    chk("rt_data_o", rt_data_o, m_rt);
    chk("dest_o", dest_o, m_dest);
    chk("dest_wr_o", dest_wr_o, m_dw);
  endtask

  task automatic wb(input logic [2:0] a, input logic [7:0] d);
    step(0, 0, 9'd0, 0, 1, a, d);
  endtask

  task automatic iss(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt);
    step(0, 1, {op, rs, rt}, 0, 0, 3'd0, 8'h00);
  endtask

  initial begin
    rst_i = 1; instr_valid_i = 0; instr_i = 0; stall_i = 0;
    wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
    for (int i = 0; i < 8; i++) begin m_rf[i] = 8'hxx; m_busy[i] = 0; end
    m_valid = 0; m_op = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_dw = 0;

    // reset with writebacks that must be ignored
    step(1, 1, 9'o133, 0, 1, 3'd3, 8'hFF);
    chk("rst_ready_lit", last_ready, 0);
    step(1, 1, 9'o133, 0, 1, 3'd7, 8'hEE);
    chk("rst_valid_lit", valid_o, 0);
    chk("rst_rs_lit", rs_data_o, 0);
    iss(3'b001, 3'd3, 3'd7);
    chk("rst_rf3_lit", rs_data_o, 8'h00);
    chk("rst_rf7_lit", rt_data_o, 8'h00);

    // bypass: registered write, then same-cycle write
    wb(3'd3, 8'h5A);
    wb(3'd7, 8'h10);
    iss(3'b001, 3'd3, 3'd7);
    chk("byp_rs_lit", rs_data_o, 8'h5A);
    chk("byp_rt_lit", rt_data_o, 8'h10);
    chk("byp_dest_lit", dest_o, 3'd3);
    chk("byp_dw_lit", dest_wr_o, 1);
    chk("byp_valid_lit", valid_o, 1);
    wb(3'd3, 8'h00);
    step(0, 1, {3'b001, 3'd3, 3'd7}, 0, 1, 3'd3, 8'h5A);
    chk("byp_same_lit", rs_data_o, 8'h5A);
    wb(3'd3, 8'h5A);

    // interlock on r2
    iss(3'b001, 3'd2, 3'd0);
    step(0, 1, {3'b010, 3'd4, 3'd2}, 0, 0, 3'd0, 8'h00);
    chk("ilk_wait1_lit", last_ready, 0);
    step(0, 1, {3'b010, 3'd4, 3'd2}, 0, 0, 3'd0, 8'h00);
    chk("ilk_wait2_lit", last_ready, 0);
    step(0, 1, {3'b010, 3'd4, 3'd2}, 0, 1, 3'd2, 8'h33);
    chk("ilk_go_lit", last_ready, 1);
    chk("ilk_rt_lit", rt_data_o, 8'h33);
    chk("ilk_dest_lit", dest_o, 3'd4);
    wb(3'd4, 8'h44);

    // unused rt ignores busy[5]
    iss(3'b001, 3'd5, 3'd5);
    iss(3'b011, 3'd1, 3'd5);
    chk("unused_rt_lit", last_ready, 1);
    chk("unused_op_lit", opcode_o, 3'b011);
    wb(3'd5, 8'h55);
    wb(3'd1, 8'h11);

    // stall hold
    iss(3'b001, 3'd0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, {3'b100, 3'd6, 3'd6}, 1, 0, 3'd0, 8'h00);
      chk("stall_ready_lit", last_ready, 0);
      chk("stall_dest_lit", dest_o, 3'd0);
      chk("stall_op_lit", opcode_o, 3'b001);
    end
    step(0, 1, {3'b100, 3'd6, 3'd6}, 0, 0, 3'd0, 8'h00);
    chk("release_dest_lit", dest_o, 3'd6);
    wb(3'd0, 8'h01);
    wb(3'd6, 8'h66);

    // flag ops do not claim their register
    iss(3'b101, 3'd6, 3'd2);
    chk("slt_dw_lit", dest_wr_o, 0);
    iss(3'b001, 3'd1, 3'd6);
    chk("slt_nobusy_lit", last_ready, 1);
    chk("slt_rt_lit", rt_data_o, 8'h66);
    wb(3'd1, 8'h21);

    // stall ignored while empty
    step(0, 0, 9'd0, 0, 0, 3'd0, 8'h00);
    step(0, 1, {3'b000, 3'd2, 3'd3}, 1, 0, 3'd0, 8'h00);
    chk("empty_stall_lit", last_ready, 1);

    // randomized traffic, including occasional mid-operation resets
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(99) == 0, $urandom_range(9) < 7, 9'($urandom),
           $urandom_range(3) == 0, $urandom_range(9) < 4,
           3'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue stage directly upstream of the 8-bit ALU. Holds the eight 8-bit architectural registers, decodes a 9-bit instruction into ALU opcode and operands, and presents them registered to the ALU. A per-register busy scoreboard interlocks on registers whose writes have not yet retired, and a same-cycle writeback bypass forwards retiring values. Writeback enters from the stage downstream of the ALU.

## Interface
- No parameters. Widths are fixed: 8-bit data, 3-bit register index, 9-bit instruction.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- instr_i  in  9  instruction: [8:6] opcode, [5:3] rs (also the destination), [2:0] rt.
- instr_valid_i  in  1  instr_i is valid this cycle.
- instr_ready_o  out  1  the stage accepts instr_i this cycle (combinational).
- stall_i  in  1  downstream cannot take a new issue; the output registers hold.
- wb_en_i  in  1  write wb_data_i into register wb_addr_i at this edge.
- wb_addr_i  in  3  writeback register index.
- wb_data_i  in  8  writeback data.
- opcode_o  out  3  registered ALU opcode.
- rs_data_o  out  8  registered rs operand.
- rt_data_o  out  8  registered rt operand.
- dest_o  out  3  registered destination index (the rs field).
- dest_wr_o  out  1  the issued instruction writes dest_o.
- valid_o  out  1  the output registers hold a live instruction.

## Operation
- Register file: 8 x 8 bits, all writable, including r0. It is written at the edge when wb_en_i=1.
- Operand read:
  - rs_val = (wb_en_i && wb_addr_i==rs) ? wb_data_i : rf[rs].
  - rt_val uses the same rule with rt.
- Operand usage per opcode:
  - rs is used by every opcode.
  - rt is used by 000, 001, 010, 100, 101 and 111. It is unused by 011 (srl) and 110 (abs).
- Destination write:
  - dest_wr = 0 for opcodes 101 (slt) and 111 (seq), which only set a flag.
  - dest_wr = 1 for all other opcodes.
- Scoreboard: 8-bit busy vector.
  - Issuing an instruction with dest_wr=1 sets busy[rs].
  - wb_en_i clears busy[wb_addr_i].
  - If a set and a clear hit the same bit in one cycle, the set wins.
- Hazard: hz = (busy[rs] && !(wb_en_i && wb_addr_i==rs)) || (rt used && busy[rt] && !(wb_en_i && wb_addr_i==rt)).
- instr_ready_o = !rst_i && !hz && !(valid_o && stall_i).
- Issue happens when instr_valid_i && instr_ready_o:
  - Load opcode_o, rs_data_o, rt_data_o, dest_o and dest_wr_o.
  - Set valid_o=1.
- No issue and no stall:
  - valid_o goes to 0.
  - The data outputs keep their last values.
- valid_o && stall_i: every output register holds, and no issue occurs.
- The stage has two states, EMPTY (valid_o=0) and FULL (valid_o=1):
  - EMPTY -> FULL on issue.
  - FULL -> EMPTY when stall_i=0 and no issue.
  - FULL -> FULL when stalled, or on a back-to-back issue.

## Timing
- Reset (rst_i=1 at an edge):
  - All registers, the busy vector, valid_o, opcode_o, rs_data_o, rt_data_o, dest_o and dest_wr_o go to 0.
  - instr_ready_o=0 while rst_i is high.
  - Any wb_en_i in a reset cycle is ignored.
  - A mid-operation reset drops the in-flight instruction and its busy bits.
- Latency: an instruction accepted at edge N appears on the outputs after edge N. The ALU samples it at edge N+1.
- Throughput: one instruction per cycle when there are no hazards and stall_i=0.
- A writeback in cycle N is visible to an instruction issued in cycle N through the bypass, with no bubble.
- A dependent instruction stalls until the cycle its producer's wb_en_i is asserted.
- Simultaneous writeback and issue with the same destination: the register takes wb_data_i, and busy stays set for the new producer.
- The stall_i input is sampled only while valid_o=1. In EMPTY, stall_i is ignored.
- All arithmetic stays in the ALU. This block does no width extension; operands pass through as 8 bits unmodified.

## Test plan
- Reset: drive rst_i for 2 cycles with wb_en_i=1 -> all outputs 0, instr_ready_o=0, registers all 0 afterwards.
- Bypass:
  - Write r3=0x5A via wb, then issue add (001) rs=3 rt=7 with r7=0x10 -> rs_data_o=0x5A, rt_data_o=0x10, dest_o=3, dest_wr_o=1, valid_o=1 the next cycle.
  - Repeat with the r3 write in the same cycle as the issue -> rs_data_o=0x5A.
- Interlock:
  - Issue add rs=2, then sub rs=4 rt=2 -> instr_ready_o=0 until wb_en_i, wb_addr_i=2, wb_data_i=0x33.
  - The sub then issues in that same cycle with rt_data_o=0x33.
- Unused rt: with busy[5]=1, issue srl (011) rs=1 rt=5 -> issues immediately.
- Stall hold: with valid_o=1, hold stall_i=1 for 3 cycles while instr_valid_i=1 -> outputs constant and instr_ready_o=0. After release, the next instruction issues.
- Flag ops: issue slt (101) rs=6 -> dest_wr_o=0, busy[6] not set. A following add rs=1 rt=6 issues without stall.
